// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/mret sequencer between commit and the M-mode CSR file
// Accepts exception/mret/timer irq, drains memory, strobes the CSR file, then redirects fetch.
module trap_ctrl #(
  parameter int DRAIN_TIMEOUT = 15,
  parameter bit VECTORED_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        irq_timer,
  input  logic        mie_mtie,
  input  logic        mstatus_mie,
  input  logic [1:0]  priv_mode,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        mem_busy,
  output logic        trap_enter,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_val,
  output logic        mret_exec,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_timeout
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           is_mret, is_irq, timeout_q;
  logic [31:0]    cause_q, pc_q, val_q;
  logic           irq_take, accept, timeout_hit;
  logic [31:0]    base;

  assign irq_take    = irq_timer & mie_mtie & (mstatus_mie | (priv_mode != 2'd3)) & commit_valid;
  assign accept      = (state == IDLE) & ~rst & (exc_valid | mret_req | irq_take);
  // Last busy DRAIN cycle before giving up: the counter would reach the limit here.
  assign timeout_hit = (state == DRAIN) & mem_busy & (cnt == CW'(DRAIN_TIMEOUT - 1));
  assign base        = {mtvec[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_mret   <= 1'b0;
      is_irq    <= 1'b0;
      timeout_q <= 1'b0;
      cause_q   <= '0;
      pc_q      <= '0;
      val_q     <= '0;
    end else begin
      state     <= state_nxt;
      timeout_q <= timeout_hit;
      if (accept) begin
        cnt <= '0;
        if (exc_valid) begin
          is_mret <= 1'b0;
          is_irq  <= 1'b0;
          cause_q <= {27'b0, exc_cause};
          pc_q    <= exc_pc;
          val_q   <= exc_tval;
        end else if (mret_req) begin
          is_mret <= 1'b1;
          is_irq  <= 1'b0;
        end else begin
          is_mret <= 1'b0;
          is_irq  <= 1'b1;
          cause_q <= 32'h8000_0007;
          pc_q    <= commit_pc;
          val_q   <= '0;
        end
      end else if (state == DRAIN && mem_busy) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = DRAIN;
      DRAIN:    if (!mem_busy || timeout_hit) state_nxt = COMMIT;
      COMMIT:   state_nxt = REDIRECT;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall          = accept | (state != IDLE);
    flush          = accept;
    trap_enter     = (state == COMMIT) & ~is_mret;
    mret_exec      = (state == COMMIT) & is_mret;
    redirect_valid = (state == REDIRECT);
    drain_timeout  = timeout_q;
    redirect_pc    = '0;
    if (state == REDIRECT) begin
      if (is_mret)
        redirect_pc = mepc;
      else if (is_irq && VECTORED_EN && mtvec[1:0] == 2'b01)
        redirect_pc = base + {25'b0, cause_q[4:0], 2'b00};
      else
        redirect_pc = base;
    end
  end

  assign trap_cause = cause_q;
  assign trap_pc    = pc_q;
  assign trap_val   = val_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl
// Expected strobes are queued at accept time and matched by a negedge monitor.
module tb_trap_ctrl;
  logic        clk = 0, rst = 1;
  logic        exc_valid = 0, mret_req = 0, commit_valid = 1, irq_timer = 0;
  logic        mie_mtie = 1, mstatus_mie = 1, mem_busy = 0;
  logic [4:0]  exc_cause = 0;
  logic [1:0]  priv_mode = 2'd3;
  logic [31:0] exc_pc = 0, exc_tval = 0, commit_pc = 0, mtvec = 0, mepc = 0;
  logic        trap_enter, mret_exec, stall, flush, redirect_valid, drain_timeout;
  logic [31:0] trap_cause, trap_pc, trap_val, redirect_pc;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .mret_req(mret_req), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .irq_timer(irq_timer), .mie_mtie(mie_mtie), .mstatus_mie(mstatus_mie), .priv_mode(priv_mode),
    .mtvec(mtvec), .mepc(mepc), .mem_busy(mem_busy), .trap_enter(trap_enter),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val), .mret_exec(mret_exec),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 trap, 1 mret, 2 timeout, 3 redirect
    int          cyc;
    logic [31:0] a, b, c;
  } ev_t;

  ev_t q[$];
  int  cyc = 0, checks = 0, failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic pop_cmp(input int kind, input logic [31:0] a, b, c);
    ev_t e;
    if (q.size() == 0) begin
      check("unexpected_strobe", kind, 32'hffff_ffff);
      return;
    end
    e = q.pop_front();
    check("ev_kind", kind, e.kind);
    check("ev_cycle", cyc, e.cyc);
    check("ev_a", a, e.a);
    if (kind == 0) begin
      check("ev_pc", b, e.b);
      check("ev_val", c, e.c);
    end
  endtask

  always @(negedge clk) begin
    if (trap_enter && mret_exec) check("exclusive_strobe", 1, 0);
    if (trap_enter)     pop_cmp(0, trap_cause, trap_pc, trap_val);
    if (mret_exec)      pop_cmp(1, 0, 0, 0);
    if (drain_timeout)  pop_cmp(2, 0, 0, 0);
    if (redirect_valid) pop_cmp(3, redirect_pc, 0, 0);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] a, b, v);
    ev_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.c = v;
    q.push_back(e);
  endtask

  // Called in the accept cycle with inputs already driven.
  task automatic seq(input logic m, input logic [31:0] cause, pc, val, rpc,
                     input int commit_off, input logic exp_to);
    int c;
    #1;
    c = cyc;
    check("accept_flush", flush, 1);
    check("accept_stall", stall, 1);
    push(m ? 1 : 0, c + commit_off, m ? 32'h0 : cause, pc, val);
    if (exp_to) push(2, c + commit_off, 0, 0, 0);
    push(3, c + commit_off + 1, rpc, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    check("rst_rv", redirect_valid, 0);
    check("rst_cause", trap_cause, 0);
    rst = 0;
    step();

    // Synchronous exception, direct mtvec
    exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h8000_0100; exc_tval = 32'hDEAD_BEEF;
    mtvec = 32'h8000_0000;
    seq(0, 32'h2, 32'h8000_0100, 32'hDEAD_BEEF, 32'h8000_0000, 2, 0);
    step(); exc_valid = 0;
    check("busy_no_flush", flush, 0);
    check("busy_stall", stall, 1);
    repeat (4) step();

    // Vectored timer interrupt
    mtvec = 32'h8000_0201; commit_pc = 32'h8000_0040; irq_timer = 1;
    seq(0, 32'h8000_0007, 32'h8000_0040, 32'h0, 32'h8000_021C, 2, 0);
    step(); irq_timer = 0;
    repeat (4) step();

    // Exception with vectored mtvec still goes to base
    exc_valid = 1; exc_cause = 5'd13; exc_pc = 32'h8000_0300; exc_tval = 32'h1234_5678;
    seq(0, 32'hD, 32'h8000_0300, 32'h1234_5678, 32'h8000_0200, 2, 0);
    step(); exc_valid = 0;
    repeat (4) step();

    // Direct-mode interrupt
    mtvec = 32'h8000_0200; commit_pc = 32'h8000_0044; irq_timer = 1;
    seq(0, 32'h8000_0007, 32'h8000_0044, 32'h0, 32'h8000_0200, 2, 0);
    step(); irq_timer = 0;
    repeat (4) step();

    // Masked in M-mode, then U-mode overrides mstatus_mie
    mstatus_mie = 0; irq_timer = 1; commit_pc = 32'h0000_1000;
    for (int i = 0; i < 20; i++) begin
      step();
      check("masked_flush", flush, 0);
      check("masked_stall", stall, 0);
    end
    step(); priv_mode = 2'd0;
    seq(0, 32'h8000_0007, 32'h0000_1000, 32'h0, 32'h8000_0200, 2, 0);
    step(); irq_timer = 0; priv_mode = 2'd3; mstatus_mie = 1;
    repeat (4) step();

    // mret wins over a pending interrupt; interrupt ignored outside IDLE
    mret_req = 1; mepc = 32'h8000_0080; irq_timer = 1; commit_pc = 32'h8000_0500;
    seq(1, 0, 0, 0, 32'h8000_0080, 2, 0);
    step(); mret_req = 0;
    for (int i = 0; i < 3; i++) begin
      check("ignored_flush", flush, 0);
      step();
    end
    irq_timer = 0;
    repeat (2) step();

    // Exception beats interrupt; interrupt stays pending until mie is cleared
    exc_valid = 1; exc_cause = 5'd4; exc_pc = 32'h8000_0600; exc_tval = 32'h0000_0003; irq_timer = 1;
    seq(0, 32'h4, 32'h8000_0600, 32'h3, 32'h8000_0200, 2, 0);
    step(); exc_valid = 0;
    step(); mstatus_mie = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("suppressed_flush", flush, 0);
    end
    irq_timer = 0; mstatus_mie = 1;
    step();

    // Drain: mem_busy high for 5 cycles starting at accept
    exc_valid = 1; exc_cause = 5'd7; exc_pc = 32'h8000_0700; exc_tval = 32'h0; mem_busy = 1;
    seq(0, 32'h7, 32'h8000_0700, 32'h0, 32'h8000_0200, 6, 0);
    step(); exc_valid = 0;
    repeat (4) step();
    mem_busy = 0;
    repeat (5) step();

    // Drain timeout: mem_busy stuck high
    exc_valid = 1; exc_cause = 5'd5; exc_pc = 32'h8000_0800; exc_tval = 32'hA5A5_0000; mem_busy = 1;
    seq(0, 32'h5, 32'h8000_0800, 32'hA5A5_0000, 32'h8000_0200, 16, 1);
    step(); exc_valid = 0;
    repeat (17) step();
    mem_busy = 0;
    repeat (3) step();
    check("queue_drained", q.size(), 0);

    // Reset during DRAIN aborts without any strobe
    exc_valid = 1; exc_cause = 5'd1; exc_pc = 32'h8000_0900; exc_tval = 32'h1; mem_busy = 1;
    #1;
    check("rst_seq_flush", flush, 1);
    step(); exc_valid = 0;
    step(); rst = 1;
    step();
    check("midrst_stall", stall, 0);
    check("midrst_flush", flush, 0);
    check("midrst_te", trap_enter, 0);
    check("midrst_me", mret_exec, 0);
    check("midrst_rv", redirect_valid, 0);
    check("midrst_rpc", redirect_pc, 0);
    check("midrst_to", drain_timeout, 0);
    check("midrst_cause", trap_cause, 0);
    check("midrst_pc", trap_pc, 0);
    check("midrst_val", trap_val, 0);
    rst = 0; mem_busy = 0;
    repeat (20) step();
    check("stays_idle", stall, 0);
    check("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap/return sequencer between the pipeline commit point and the Machine-mode CSR register file.
- Arbitrates synchronous exceptions, `mret`, and the machine timer interrupt.
- Stalls and flushes the pipeline, drains outstanding memory traffic, then fires a single-cycle trap_enter or mret_exec into the CSR file.
- Finally issues one PC redirect: mtvec for traps, honouring vectored mode, or mepc for mret.

Parameters:
- DRAIN_TIMEOUT, 15: maximum DRAIN cycles waiting for mem_busy to fall before proceeding anyway.
- VECTORED_EN, 1: 1 = honour mtvec MODE=1 (vectored) for interrupts; 0 = always direct.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- exc_valid  in  1  commit-stage instruction raised a synchronous exception
- exc_cause  in  5  exception code
- exc_pc  in  32  PC of the faulting instruction
- exc_tval  in  32  faulting address or instruction value
- mret_req  in  1  commit-stage instruction is mret
- commit_valid  in  1  a valid instruction sits at commit
- commit_pc  in  32  PC of that instruction
- irq_timer  in  1  timer interrupt pending (MTIP)
- mie_mtie  in  1  timer interrupt enable
- mstatus_mie  in  1  global interrupt enable
- priv_mode  in  2  current privilege (0=U, 3=M)
- mtvec  in  32  trap vector CSR
- mepc  in  32  exception PC CSR
- mem_busy  in  1  data/instruction bus transaction outstanding
- trap_enter  out  1  one-cycle trap commit strobe to CSR file
- trap_cause  out  32  mcause value
- trap_pc  out  32  mepc value
- trap_val  out  32  mtval value
- mret_exec  out  1  one-cycle mret strobe to CSR file
- stall  out  1  freeze pipeline
- flush  out  1  kill all in-flight instructions
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target
- drain_timeout  out  1  one-cycle pulse: drain abandoned on timeout

Behaviour:
- **Clock and reset.** Single clock domain. Reset is synchronous and active-high: on rst, state=IDLE, drain counter=0, and every output plus the latched cause/pc/val/kind registers are 0. Reset mid-sequence aborts the sequence with no strobe.
- **FSM states.** IDLE, DRAIN, COMMIT, REDIRECT.
- **Interrupt take condition.** irq_take = irq_timer & mie_mtie & (mstatus_mie | priv_mode!=3) & commit_valid.
- **Accept in IDLE.** Priority is exc_valid > mret_req > irq_take. Accept is the OR of the three. On accept:
  - flush=1 and stall=1 combinationally in the same cycle; the committing instruction does not retire.
  - Latch kind and values, then go to DRAIN with counter=0:
    - exception: cause={27'b0,exc_cause}, pc=exc_pc, val=exc_tval.
    - interrupt: cause=0x8000_0007, pc=commit_pc, val=0.
    - mret: no values latched.
- **stall.** stall=1 in every non-IDLE state. flush is high only in the accept cycle.
- **DRAIN.** Minimum 1 cycle.
  - If mem_busy=0: go to COMMIT.
  - Else the counter increments. When the counter reaches DRAIN_TIMEOUT with mem_busy still 1, pulse drain_timeout and go to COMMIT.
- **COMMIT.** Exactly 1 cycle.
  - Trap: trap_enter=1 with trap_cause/trap_pc/trap_val driven from the latches.
  - mret: mret_exec=1.
  - trap_cause/pc/val hold their last value otherwise; they are only meaningful with trap_enter.
  - Next state is REDIRECT.
- **REDIRECT.** Exactly 1 cycle with redirect_valid=1, then IDLE.
  - base = {mtvec[31:2],2'b00}.
  - Interrupt with VECTORED_EN=1 and mtvec[1:0]=1: redirect_pc = base + (cause[4:0]<<2), mod 2^32.
  - Any other trap: redirect_pc = base.
  - mret: redirect_pc = mepc sampled in this cycle.
- **Output timing.** trap_enter, mret_exec, redirect_valid, redirect_pc and drain_timeout are Moore outputs decoded from registered state and latches. Minimum latency: accept at cycle T, trap_enter/mret_exec at T+2, redirect_valid at T+3, IDLE at T+4.
- **Events outside IDLE.** exc_valid, mret_req and irq_take are ignored in non-IDLE states. A held interrupt is re-evaluated after returning to IDLE; after a trap, mstatus_mie=0 in M-mode suppresses it.
- **Simultaneous events.** exc_valid with irq_take: the exception is taken and the interrupt stays pending. mret_req with irq_take: mret is taken.
- **Exclusivity.** Never trap_enter and mret_exec in the same cycle; never two strobes per sequence.

Test Plan:
1. **Synchronous exception.**
   - Stimulus: exc_valid=1, exc_cause=2, exc_pc=0x8000_0100, exc_tval=0xDEAD_BEEF, mtvec=0x8000_0000, mem_busy=0.
   - Required response: flush at T; trap_enter at T+2 with cause=0x2, pc=0x8000_0100, val=0xDEAD_BEEF; redirect_pc=0x8000_0000 at T+3.
2. **Vectored timer interrupt.**
   - Stimulus: irq_timer=mie_mtie=mstatus_mie=1, priv_mode=3, commit_pc=0x8000_0040, mtvec=0x8000_0201.
   - Required response: trap_enter with cause=0x8000_0007, pc=0x8000_0040, val=0; redirect_pc=0x8000_021C. Repeat with VECTORED_EN=0 or mtvec=0x8000_0200: redirect_pc=0x8000_0200.
3. **Interrupt masking and U-mode override.**
   - Stimulus: mstatus_mie=0, priv_mode=3, timer pending.
   - Required response: no accept for 20 cycles. Switch priv_mode=0: accepted next cycle.
4. **mret.**
   - Stimulus: mret_req=1, mepc=0x8000_0080, with timer interrupt pending in the same cycle.
   - Required response: mret_exec at T+2 with trap_enter=0; redirect_pc=0x8000_0080 at T+3.
5. **Drain.**
   - Stimulus: exception accepted with mem_busy=1 for 5 cycles.
   - Required response: trap_enter exactly 1 cycle after mem_busy falls, no drain_timeout. With mem_busy stuck at 1: drain_timeout and COMMIT after 15 DRAIN cycles.
6. **Reset mid-sequence.**
   - Stimulus: assert rst during DRAIN.
   - Required response: next cycle all outputs 0, IDLE; no trap_enter or redirect_valid is ever emitted for that sequence.
